// File: rtl/l1d_package.sv
// Shared L1D definitions used by the data-RAM request path.
package l1d_package;

   localparam int L1D_MSHR_ENTRY_NUM = 4;
   localparam int L1D_MSHR_ID_WIDTH  = 2;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef struct packed {
      logic [L1D_MSHR_ID_WIDTH-1:0] mshr_id;
      logic                         wr_en;
      logic [5:0]                   set_idx;
      logic [3:0]                   way_idx;
      logic [31:0]                  data;
   } pack_data_ram_req_pld;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/vrp_arb_rr_lock.sv
// Burst-aware arbiter: winner search, round-robin pointer and burst lock FSM.
//
// state    | meaning
// ARB_IDLE | unlocked; winner picked by round-robin or fixed priority
// ARB_LOCK | mid-burst; only lock_idx may be granted until its last beat
module vrp_arb_rr_lock
   import l1d_package::*;
#(
   parameter int REQ_NUM  = L1D_MSHR_ENTRY_NUM,
   parameter int ARB_MODE = ARB_RR,
   parameter int IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REQ_NUM-1:0] vld,
   input  logic [REQ_NUM-1:0] last,
   input  logic               stage_free,
   output logic [REQ_NUM-1:0] rdy,
   output logic               grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_last
);

   arb_state_e       state, state_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0] lock_idx, lock_idx_nxt;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             win_found;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      if (state == ARB_LOCK) begin
         win_found = vld[lock_idx];
         win_idx   = lock_idx;
      end else begin
         for (int k = 0; k < REQ_NUM; k++) begin
            if (ARB_MODE == ARB_FIXED)
               cand = IDX_W'(k);
            else
               cand = IDX_W'((int'(rr_ptr) + k) % REQ_NUM);
            if (!win_found && vld[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end
   end

   // Ready depends only on valids, lock state and the output stage.
   assign grant      = win_found && stage_free && !rst;
   assign grant_idx  = win_idx;
   assign grant_last = last[win_idx];
   assign rdy        = grant ? (REQ_NUM'(1) << win_idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         lock_idx <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         lock_idx <= lock_idx_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      lock_idx_nxt = lock_idx;
      case (state)
         ARB_IDLE: begin
            if (grant && !grant_last) begin
               state_nxt    = ARB_LOCK;
               lock_idx_nxt = win_idx;
            end
         end
         ARB_LOCK: begin
            if (grant && grant_last)
               state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
      // Pointer only advances at burst end so a burst never splits fairness.
      if (grant && grant_last) begin
         if (win_idx == IDX_W'(REQ_NUM - 1))
            rr_ptr_nxt = '0;
         else
            rr_ptr_nxt = win_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/vrp_data_ram_arb_burst.sv
// Data-RAM request arbiter with burst locking and a single registered output stage.
module vrp_data_ram_arb_burst
   import l1d_package::*;
#(
   parameter int REQ_NUM  = L1D_MSHR_ENTRY_NUM,
   parameter int ARB_MODE = ARB_RR,
   parameter int IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REQ_NUM-1:0]   v_in_vld,
   output logic [REQ_NUM-1:0]   v_in_rdy,
   input  pack_data_ram_req_pld v_in_pld [REQ_NUM],
   input  logic [REQ_NUM-1:0]   v_in_last,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output pack_data_ram_req_pld out_pld,
   output logic [IDX_W-1:0]     out_idx,
   output logic                 out_last
);

   logic             stage_free;
   logic             grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_last;

   assign stage_free = !out_vld || out_rdy;

   vrp_arb_rr_lock #(
      .REQ_NUM  (REQ_NUM),
      .ARB_MODE (ARB_MODE),
      .IDX_W    (IDX_W)
   ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .vld        (v_in_vld),
      .last       (v_in_last),
      .stage_free (stage_free),
      .rdy        (v_in_rdy),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_last (grant_last)
   );

   always_ff @(posedge clk) begin
      if (rst)
         out_vld <= 1'b0;
      else if (stage_free)
         out_vld <= grant;
   end

   // grant is already masked by stage_free and rst, so a held beat is never overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_pld  <= '0;
         out_idx  <= '0;
         out_last <= 1'b0;
      end else if (grant) begin
         out_pld  <= v_in_pld[grant_idx];
         out_idx  <= grant_idx;
         out_last <= grant_last;
      end
   end

endmodule

// File: tb/tb_vrp_data_ram_arb_burst.sv
// Bench for vrp_data_ram_arb_burst: round-robin x4, fixed-priority x4 and single-requester instances.
module tb_vrp_data_ram_arb_burst;
   import l1d_package::*;

   typedef pack_data_ram_req_pld pld_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] vld  [3];
   logic [3:0] last [3];
   pld_t       pld  [3][4];
   logic       ordy [3];

   pld_t pld_a [4];
   pld_t pld_b [4];
   pld_t pld_c [1];
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pld_a[i] = pld[0][i];
         pld_b[i] = pld[1][i];
      end
      pld_c[0] = pld[2][0];
   end

   logic [3:0] rdy_a, rdy_b;
   logic [0:0] rdy_c;
   logic       ov_a, ov_b, ov_c;
   pld_t       op_a, op_b, op_c;
   logic [1:0] oi_a, oi_b;
   logic [0:0] oi_c;
   logic       ol_a, ol_b, ol_c;

   vrp_data_ram_arb_burst #(.REQ_NUM(4), .ARB_MODE(ARB_RR)) dut_a (
      .clk(clk), .rst(rst), .v_in_vld(vld[0]), .v_in_rdy(rdy_a), .v_in_pld(pld_a),
      .v_in_last(last[0]), .out_vld(ov_a), .out_rdy(ordy[0]), .out_pld(op_a),
      .out_idx(oi_a), .out_last(ol_a));

   vrp_data_ram_arb_burst #(.REQ_NUM(4), .ARB_MODE(ARB_FIXED)) dut_b (
      .clk(clk), .rst(rst), .v_in_vld(vld[1]), .v_in_rdy(rdy_b), .v_in_pld(pld_b),
      .v_in_last(last[1]), .out_vld(ov_b), .out_rdy(ordy[1]), .out_pld(op_b),
      .out_idx(oi_b), .out_last(ol_b));

   vrp_data_ram_arb_burst #(.REQ_NUM(1), .ARB_MODE(ARB_RR)) dut_c (
      .clk(clk), .rst(rst), .v_in_vld(vld[2][0:0]), .v_in_rdy(rdy_c), .v_in_pld(pld_c),
      .v_in_last(last[2][0:0]), .out_vld(ov_c), .out_rdy(ordy[2]), .out_pld(op_c),
      .out_idx(oi_c), .out_last(ol_c));

   logic [3:0] rdy_o [3];
   logic       ov_o  [3];
   pld_t       op_o  [3];
   logic [1:0] oi_o  [3];
   logic       ol_o  [3];
   always_comb begin
      rdy_o[0] = rdy_a;        rdy_o[1] = rdy_b;        rdy_o[2] = {3'b000, rdy_c};
      ov_o[0]  = ov_a;         ov_o[1]  = ov_b;         ov_o[2]  = ov_c;
      op_o[0]  = op_a;         op_o[1]  = op_b;         op_o[2]  = op_c;
      oi_o[0]  = oi_a;         oi_o[1]  = oi_b;         oi_o[2]  = {1'b0, oi_c};
      ol_o[0]  = ol_a;         ol_o[1]  = ol_b;         ol_o[2]  = ol_c;
   end

   // Reference model: who owns the port, where the fairness pointer sits, what the output holds.
   int   nreq [3] = '{4, 4, 1};
   int   mode [3] = '{0, 1, 0};
   int   m_ptr [3];
   int   m_owner [3];
   bit   m_locked [3];
   bit   m_ov [3];
   pld_t m_op [3];
   int   m_oi [3];
   bit   m_ol [3];

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(int d);
      int j;
      if (rst) return -1;
      if (m_ov[d] && !ordy[d]) return -1;
      if (m_locked[d]) return vld[d][m_owner[d]] ? m_owner[d] : -1;
      for (int k = 0; k < nreq[d]; k++) begin
         j = (mode[d] == 1) ? k : (m_ptr[d] + k) % nreq[d];
         if (vld[d][j]) return j;
      end
      return -1;
   endfunction

   task automatic randomize_pld();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 4; i++)
            pld[d][i] = pld_t'({$urandom, $urandom});
   endtask

   // One clock: check readies before the edge, advance the model at the edge, check outputs after.
   task automatic step();
      int         w [3];
      logic [3:0] exp_rdy;
      #1;
      for (int d = 0; d < 3; d++) begin
         w[d]    = winner(d);
         exp_rdy = (w[d] < 0) ? 4'b0000 : 4'(1 << w[d]);
         chk($sformatf("rdy[%0d]", d), 64'(rdy_o[d]), 64'(exp_rdy));
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_ov[d] = 0; m_locked[d] = 0; m_ptr[d] = 0; m_owner[d] = 0;
         end else begin
            if (!m_ov[d] || ordy[d]) begin
               m_ov[d] = (w[d] >= 0);
               if (w[d] >= 0) begin
                  m_op[d] = pld[d][w[d]];
                  m_oi[d] = w[d];
                  m_ol[d] = last[d][w[d]];
               end
            end
            if (w[d] >= 0) begin
               if (last[d][w[d]]) begin
                  m_locked[d] = 0;
                  m_ptr[d]    = (w[d] + 1) % nreq[d];
               end else begin
                  m_locked[d] = 1;
                  m_owner[d]  = w[d];
               end
            end
         end
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("out_vld[%0d]", d), 64'(ov_o[d]), 64'(m_ov[d]));
         if (m_ov[d]) begin
            chk($sformatf("out_idx[%0d]", d), 64'(oi_o[d]), 64'(m_oi[d]));
            chk($sformatf("out_pld[%0d]", d), 64'(op_o[d]), 64'(m_op[d]));
            chk($sformatf("out_last[%0d]", d), 64'(ol_o[d]), 64'(m_ol[d]));
         end
      end
   endtask

   task automatic drive(int d, logic [3:0] v, logic [3:0] l, logic r);
      vld[d]  = v;
      last[d] = l;
      ordy[d] = r;
   endtask

   initial begin
      int         rr_seq [5] = '{0, 1, 2, 3, 0};
      int         burst_idx [6] = '{1, 1, -1, -1, 1, 2};
      logic [3:0] burst_vld [6] = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b0100};
      logic [3:0] burst_lst [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100};

      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         drive(d, 4'b0000, 4'b1111, 1'b1);
         m_ptr[d] = 0; m_owner[d] = 0; m_locked[d] = 0; m_ov[d] = 0;
         m_op[d] = '0; m_oi[d] = 0; m_ol[d] = 0;
      end
      randomize_pld();
      @(negedge clk);
      step();
      step();
      chk("reset_out_vld_a", 64'(ov_a), 64'(0));
      rst = 1'b0;

      // All four requesting single beats: strict rotation; fixed-priority sticks to idx 1.
      drive(0, 4'b1111, 4'b1111, 1'b1);
      drive(1, 4'b1010, 4'b1111, 1'b1);
      drive(2, 4'b0001, 4'b0001, 1'b1);
      for (int c = 0; c < 5; c++) begin
         randomize_pld();
         step();
         chk($sformatf("rr_seq_%0d", c), 64'(oi_a), 64'(rr_seq[c]));
         chk($sformatf("fixed_idx1_%0d", c), 64'(oi_b), 64'(1));
      end

      drive(0, 4'b0000, 4'b1111, 1'b1);
      drive(1, 4'b1000, 4'b1111, 1'b1);
      step();
      chk("fixed_idx3_after_drop", 64'(oi_b), 64'(3));
      chk("drain_out_vld_a", 64'(ov_a), 64'(0));

      // Three-beat burst from req1 with a two-cycle gap; req2 must wait.
      for (int c = 0; c < 6; c++) begin
         drive(0, burst_vld[c], burst_lst[c], 1'b1);
         drive(1, 4'($urandom_range(0, 15)), 4'($urandom), 1'b1);
         randomize_pld();
         step();
         chk($sformatf("burst_vld_%0d", c), 64'(ov_a), 64'(burst_idx[c] >= 0));
         if (burst_idx[c] >= 0)
            chk($sformatf("burst_idx_%0d", c), 64'(oi_a), 64'(burst_idx[c]));
      end

      // Backpressure: fill, stall five cycles, then release.
      drive(0, 4'b1111, 4'b1111, 1'b1);
      step();
      for (int c = 0; c < 5; c++) begin
         drive(0, 4'b1111, 4'b1111, 1'b0);
         randomize_pld();
         step();
         chk($sformatf("stall_rdy_%0d", c), 64'(rdy_a), 64'(0));
      end
      drive(0, 4'b1111, 4'b1111, 1'b1);
      step();
      step();

      // Reset in the middle of a burst from req3.
      drive(0, 4'b0000, 4'b1111, 1'b1);
      step();
      drive(0, 4'b1000, 4'b0000, 1'b1);
      step();
      chk("pre_reset_idx3", 64'(oi_a), 64'(3));
      rst = 1'b1;
      step();
      chk("reset_mid_burst_vld", 64'(ov_a), 64'(0));
      rst = 1'b0;
      drive(0, 4'b1001, 4'b1111, 1'b1);
      step();
      chk("post_reset_vld", 64'(ov_a), 64'(1));
      chk("post_reset_idx0", 64'(oi_a), 64'(0));

      // Random traffic on all three instances.
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 3; d++)
            drive(d, 4'($urandom_range(0, 15)), 4'($urandom), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) rst = 1'b1;
         randomize_pld();
         step();
         rst = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vrp_data_ram_arb_burst.md
VRP_DATA_RAM_ARB_BURST -- requirements
Module: vrp_data_ram_arb_burst

Interface
REQ-001 Parameter REQ_NUM, default L1D_MSHR_ENTRY_NUM, number of requesters (>=1).
REQ-002 Parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-003 Parameter IDX_W, default max(1, clog2(REQ_NUM)), width of the grant index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 v_in_vld  input  REQ_NUM  per-requester valid.
REQ-007 v_in_rdy  output  REQ_NUM  per-requester ready; at most one bit set.
REQ-008 v_in_pld  input  REQ_NUM x pack_data_ram_req_pld  per-requester payload.
REQ-009 v_in_last  input  REQ_NUM  per-requester last-beat flag of a multi-beat burst.
REQ-010 out_vld  output  1  registered output valid.
REQ-011 out_rdy  input  1  downstream ready.
REQ-012 out_pld  output  pack_data_ram_req_pld  registered payload of the granted beat.
REQ-013 out_idx  output  IDX_W  requester index of the beat in out_pld.
REQ-014 out_last  output  1  registered last flag of the beat in out_pld.

Function
REQ-015 A transfer on input i occurs in a cycle when v_in_vld[i] and v_in_rdy[i] are both high; a transfer on the output occurs when out_vld and out_rdy are both high.
REQ-016 The output is one register stage: stage_free = !out_vld || out_rdy; v_in_rdy is all-zero when stage_free is low.
REQ-017 When stage_free is high, v_in_rdy asserts only for the winner; v_in_rdy never depends on out_pld or on any v_in_pld.
REQ-018 An accepted beat appears on out_vld/out_pld/out_idx/out_last the next cycle (latency 1); back-to-back acceptance gives one beat per cycle.
REQ-019 out_* hold stable while out_vld high and out_rdy low.
REQ-020 Arbiter states: IDLE (unlocked) and LOCK (owner = lock_idx).
REQ-021 IDLE, ARB_MODE=0: winner is the first requester with v_in_vld high searching from rr_ptr upward, wrapping from REQ_NUM-1 to 0.
REQ-022 IDLE, ARB_MODE=1: winner is the lowest index with v_in_vld high; rr_ptr ignored.
REQ-023 IDLE -> LOCK when a beat with v_in_last low is accepted; lock_idx := that index.
REQ-024 LOCK: only lock_idx is eligible; other requesters get no ready even if the owner drops v_in_vld (bubble allowed, no preemption).
REQ-025 LOCK -> IDLE when the owner's beat with v_in_last high is accepted.
REQ-026 rr_ptr := (idx+1) mod REQ_NUM only when a beat with v_in_last high is accepted from idx (burst end or single beat); otherwise unchanged.
REQ-027 No valid inputs in IDLE: no ready, state and rr_ptr unchanged.
REQ-028 REQ_NUM=1: block behaves as a one-stage register slice; out_idx is 0.
REQ-029 Simultaneous output drain and new acceptance in one cycle is required (full throughput); out_vld stays high.

Reset
REQ-030 While rst is high at a clock edge: out_vld:=0, state:=IDLE, rr_ptr:=0, lock_idx:=0; out_pld/out_idx/out_last are don't-care.
REQ-031 v_in_rdy is all-zero in every cycle rst is high.
REQ-032 Reset mid-burst abandons the lock and drops any held beat; the first post-reset grant follows REQ-021/022 from rr_ptr=0.

Structure
REQ-033 pack_data_ram_req_pld, L1D_MSHR_ENTRY_NUM and L1D_MSHR_ID_WIDTH are taken from l1d_package; ARB_MODE encoding constants (ARB_RR, ARB_FIXED) are added to l1d_package.
REQ-034 One sub-module vrp_arb_rr_lock holds the winner search, rr_ptr and lock FSM; the top holds the payload mux and output register.

Verification
REQ-035 REQ_NUM=4, ARB_MODE=0, vld=4'b1111 all last=1, out_rdy=1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles, first out_vld one cycle after first acceptance.
REQ-036 Req1 sends 3-beat burst (last on beat 3), req2 valid throughout -> out_idx 1,1,1 then 2; req1 dropping vld for 2 cycles mid-burst gives output bubbles, req2 not granted.
REQ-037 out_rdy low for 5 cycles with out_vld high -> out_* stable, v_in_rdy all-zero; out_rdy high -> drain and new accept in same cycle.
REQ-038 ARB_MODE=1, vld=4'b1010, all last=1 -> idx 1 granted every cycle while vld[1] high; idx 3 only after vld[1] drops.
REQ-039 rst asserted in cycle 2 of a 4-beat burst from req3 -> next cycle out_vld=0; after release with vld=4'b1001, idx 0 granted first.
REQ-040 REQ_NUM=1 random vld/rdy/pld -> out stream equals accepted input stream, order preserved, no loss or duplication.
